// File: rtl/blinker_pkg.sv
// Shared constants and pattern helpers for the LED blinker: mode encodings,
// shift direction, per-mode init values and the step-period computation.
package blinker_pkg;

  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam int STEP_SHIFT = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [7:0] INIT_BLINK  = 8'h00;
  localparam logic [7:0] INIT_ROTATE = 8'h01;
  localparam logic [7:0] INIT_BOUNCE = 8'h01;
  localparam logic [7:0] INIT_COUNT  = 8'h00;

  typedef struct packed {
    logic [7:0] led;
    logic       dir;
  } pattern_t;

  function automatic logic [7:0] init_led(input logic [1:0] mode);
    logic [7:0] r;
    case (mode)
      MODE_BLINK:  r = INIT_BLINK;
      MODE_ROTATE: r = INIT_ROTATE;
      MODE_BOUNCE: r = INIT_BOUNCE;
      MODE_COUNT:  r = INIT_COUNT;
      default:     r = INIT_BLINK;
    endcase
    return r;
  endfunction

  // Bounce flips direction on the step that lands on an end, so ends never repeat.
  function automatic pattern_t next_pattern(input logic [1:0] mode,
                                            input logic [7:0] led,
                                            input logic       dir);
    pattern_t r;
    r.led = led;
    r.dir = dir;
    case (mode)
      MODE_BLINK:  r.led = ~led;
      MODE_ROTATE: r.led = {led[6:0], led[7]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          r.led = {led[6:0], 1'b0};
          r.dir = (r.led == 8'h80) ? DIR_RIGHT : DIR_LEFT;
        end else begin
          r.led = {1'b0, led[7:1]};
          r.dir = (r.led == 8'h01) ? DIR_LEFT : DIR_RIGHT;
        end
      end
      MODE_COUNT:  r.led = led + 8'd1;
      default:     r.led = led;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] period_m1(input logic [3:0] delay);
    logic [3:0] dsel;
    dsel = (delay == 4'd0) ? 4'd1 : delay;
    return ({4'b0000, dsel} << STEP_SHIFT) - 8'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running base-tick divider: counts 0..TICK_DIV-1 and flags the last count.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre_cnt_q;
  logic [CW-1:0] pre_cnt_d;

  always_comb begin
    if (clear) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == LAST) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign tick = (pre_cnt_q == LAST);

endmodule

// File: rtl/led_blinker.sv
// LED pattern generator: divides base ticks into a delay-selected step period
// and advances one of four LED patterns on each step.
module led_blinker
  import blinker_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int LED_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       delay,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             step
);

  logic [1:0]       mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             tick;
  logic             mode_chg;
  pattern_t         nxt;

  assign mode_chg = (mode != mode_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (mode_chg | ~enable),
    .tick  (tick)
  );

  // Mode change outranks disable, which outranks a step.
  always_comb begin
    mode_d     = mode;
    led_d      = led_q;
    dir_d      = dir_q;
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;
    nxt        = next_pattern(mode_q, led_q, dir_q);
    if (mode_chg) begin
      led_d      = init_led(mode);
      dir_d      = DIR_LEFT;
      step_cnt_d = 8'd0;
    end else if (!enable) begin
      step_cnt_d = 8'd0;
    end else if (tick) begin
      if (step_cnt_q >= period_m1(delay)) begin
        step_cnt_d = 8'd0;
        led_d      = nxt.led;
        dir_d      = nxt.dir;
        step_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 8'd1;
      end
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_BLINK;
      led_q      <= '0;
      dir_q      <= DIR_LEFT;
      step_q     <= 1'b0;
      step_cnt_q <= 8'd0;
    end else begin
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: doc/led_blinker.md
# led_blinker

Pattern generator that drives the board LEDs. It consumes the 4-bit `delay` value produced by the delay controller and turns it into a step period. On every step it advances one of four LED patterns selected by `mode`. It sits between the delay controller and the top-level LED pins, and emits a one-cycle `step` pulse for other logic to use.

## Interface
- `TICK_DIV`, default 50000: clk cycles per base tick (1 ms at 50 MHz); must be ≥ 2.
- `LED_W`, default 8: number of LEDs; fixed at 8 for this revision.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run pattern when high; freeze when low.
- `delay`  in  4  step period selector from the delay controller.
- `mode`  in  2  pattern select: 0 blink, 1 rotate, 2 bounce, 3 count.
- `led`  out  8  registered LED drive, bit 0 = rightmost LED.
- `step`  out  1  registered one-cycle pulse, high in the cycle `led` takes a new step value.

## Operation
- **Prescaler `pre_cnt`** counts 0..TICK_DIV-1 and wraps. `tick` is high when `pre_cnt == TICK_DIV-1`.
- **Period:** period P = max(delay,1) × 16 ticks. `delay == 0` is treated as 1. Range is 16..240 ticks.
- **Step counter:** on `tick`, `step_cnt` increments.
  - When `tick && step_cnt >= P-1`: `step_cnt` ← 0, the pattern advances, and `step` ← 1.
- **Delay change mid-period:** `delay` is sampled every cycle with no latching.
  - If the new P-1 ≤ current `step_cnt`, the step fires on the next tick.
  - Otherwise the period extends to the new P.
- **Mode change:** `mode_q` registers `mode`.
  - When `mode != mode_q`, on the next clock: `led` loads the init value of the new mode, `dir` ← LEFT, `pre_cnt` and `step_cnt` ← 0, and `step` stays 0.
  - Mode change has priority over a step in the same cycle.
- **Patterns (next value on step):**
  - Blink: init 8'h00, `led` ← ~`led`.
  - Rotate: init 8'h01, rotate left; 8'h80 → 8'h01.
  - Bounce: init 8'h01, `dir` LEFT.
    - LEFT shifts left. Reaching 8'h80 sets `dir` RIGHT.
    - RIGHT shifts right. Reaching 8'h01 sets `dir` LEFT.
    - Full sequence: 01, 02, …, 80, 40, …, 01, 02, … Ends are not repeated.
  - Count: init 8'h00, `led` ← `led` + 1, wrapping 8'hFF → 8'h00.
- **Enable low:** `pre_cnt` and `step_cnt` are cleared, `led` and `dir` hold, `step` is 0. `mode_q` still tracks, so a mode change while disabled still loads the init value.
- **Re-enable:** the first step comes a full P ticks later.

## Timing
- **Reset values:** `led` 8'h00, `step` 0, `mode_q` 2'b00, `dir` LEFT, `pre_cnt` 0, `step_cnt` 0.
  - If `mode` is nonzero at reset release, the init value loads 1 cycle later.
- **Reset mid-operation:** reset asserted at any time forces all reset values immediately, asynchronously.
- **Step cycle:** the step condition is evaluated combinationally from registered counters. `led` and `step` update on the following clock edge.
- **Step spacing:** with `enable` high and constant `delay`/`mode`, consecutive `step` pulses are exactly P × TICK_DIV cycles apart. The first step after reset or mode change comes P × TICK_DIV cycles after the counters clear.
- **Step width:** `step` is never high for 2 consecutive cycles.
- **Handshake:** none; `delay` is a level input.
- **Counter widths:**
  - `pre_cnt` is clog2(TICK_DIV) bits.
  - `step_cnt` is 8 bits, which holds up to 240 ticks.
  - The P computation uses 8 bits: `{max(delay,1), 4'b0000}`.

## Structure
- **Shared package/header `blinker_pkg`:**
  - mode encodings MODE_BLINK = 0, MODE_ROTATE = 1, MODE_BOUNCE = 2, MODE_COUNT = 3
  - STEP_SHIFT = 4
  - DIR_LEFT / DIR_RIGHT
  - per-mode init constants
- **Sub-module `tick_prescaler`:** parameter TICK_DIV; ports `clk`, `reset`, `clear`, outputs `tick`. The rest stays in `led_blinker`: step counter, mode tracking, pattern logic.

## Test plan
All scenarios use TICK_DIV = 4, so one step at `delay` = 1 is 64 clk cycles.

- **Reset and first step:** release reset with `mode` = 0, `enable` = 1, `delay` = 1 → `led` = 8'h00, `step` = 0. After 64 cycles: `step` pulse and `led` = 8'hFF. After 64 more: `led` = 8'h00.
- **Bounce turnaround:** `mode` = 2, `delay` = 1 → sequence 01, 02, 04, …, 80, 40, …, 01, 02, with steps 64 cycles apart and no repeated 80 or 01.
- **Rotate and count wrap:**
  - `mode` = 1: `led` goes 80 → 01.
  - `mode` = 3, preloaded by stepping 255 times: `led` goes FF → 00.
- **Delay change mid-period:**
  - `delay` = 15 (period 960 cycles); at `step_cnt` = 100, set `delay` = 1 → `step` on the next tick, 4 cycles later at most.
  - From `delay` = 1, set `delay` = 15 → the next step comes 960 cycles after the previous one.
  - `delay` = 0 → same period as `delay` = 1.
- **Mode change and enable:**
  - Change `mode` 3 → 2 mid-period → `led` = 8'h01 1 cycle later, no `step`, next step 64 cycles later.
  - `enable` low for 500 cycles → `led` holds and no `step`; re-enable → step 64 cycles later.
- **Async reset mid-pattern:** assert `reset` between clock edges while `led` = 8'h40 → `led` = 8'h00 and `step` = 0 before the next edge.
